// File: rtl/fighter_pkg.sv
// Encodings shared between the per-player sequencer and the hit-detection block.
package fighter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FORWARD   = 4'd1,
        ST_BACKWARD  = 4'd2,
        ST_IA_START  = 4'd3,
        ST_IA_ACTIVE = 4'd4,
        ST_IA_RECOV  = 4'd5,
        ST_DA_START  = 4'd6,
        ST_DA_ACTIVE = 4'd7,
        ST_DA_RECOV  = 4'd8,
        ST_HITSTUN   = 4'd9,
        ST_BLOCKSTUN = 4'd10
    } state_e;

    localparam logic [1:0] SM_NEUTRAL = 2'b00;
    localparam logic [1:0] SM_HIT     = 2'b01;
    localparam logic [1:0] SM_BLOCK   = 2'b10;
    localparam logic [1:0] SM_WHIFF   = 2'b11;

    // Attack phases and stun states run off frames_left; movement states do not.
    function automatic logic is_timed(input state_e s);
        return (s >= ST_IA_START) && (s <= ST_BLOCKSTUN);
    endfunction

endpackage

// File: rtl/fighter_state_ctrl.sv
// Per-player combat sequencer: movement, neutral/directional attack phases and
// stun states, stepped once per frame_tick, with health and sticky KO.
import fighter_pkg::*;

module fighter_state_ctrl #(
    parameter int unsigned IA_START      = 5,
    parameter int unsigned IA_ACTIVE     = 2,
    parameter int unsigned IA_RECOV      = 16,
    parameter int unsigned DA_START      = 4,
    parameter int unsigned DA_ACTIVE     = 3,
    parameter int unsigned DA_RECOV      = 15,
    parameter int unsigned HITSTUN_LEN   = 15,
    parameter int unsigned BLOCKSTUN_LEN = 12,
    parameter int unsigned HEALTH_INIT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_fwd,
    input  logic       move_back,
    input  logic       attack,
    input  logic [1:0] stunmode,
    output logic [3:0] state,
    output logic [4:0] frames_left,
    output logic [1:0] health,
    output logic       hit_pulse,
    output logic       ko
);

    localparam logic [4:0] L_IA_START  = 5'(IA_START);
    localparam logic [4:0] L_IA_ACTIVE = 5'(IA_ACTIVE);
    localparam logic [4:0] L_IA_RECOV  = 5'(IA_RECOV);
    localparam logic [4:0] L_DA_START  = 5'(DA_START);
    localparam logic [4:0] L_DA_ACTIVE = 5'(DA_ACTIVE);
    localparam logic [4:0] L_DA_RECOV  = 5'(DA_RECOV);
    localparam logic [4:0] L_HITSTUN   = 5'(HITSTUN_LEN);
    localparam logic [4:0] L_BLOCKSTUN = 5'(BLOCKSTUN_LEN);
    localparam logic [1:0] L_HEALTH    = 2'(HEALTH_INIT);

    state_e     state_q;
    logic [4:0] frames_q;
    logic [1:0] health_q;
    logic       hit_pulse_q;
    logic       ko_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frames_q    <= 5'd0;
            health_q    <= L_HEALTH;
            hit_pulse_q <= 1'b0;
            ko_q        <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (frame_tick) begin
                if (ko_q || (state_q > ST_BLOCKSTUN)) begin
                    state_q  <= ST_IDLE;
                    frames_q <= 5'd0;
                end else if ((stunmode == SM_HIT) && (state_q != ST_HITSTUN)) begin
                    // A hit lands even mid-attack (trade); KO flags on the same tick.
                    state_q     <= ST_HITSTUN;
                    frames_q    <= L_HITSTUN;
                    hit_pulse_q <= 1'b1;
                    health_q    <= (health_q == 2'd0) ? 2'd0 : health_q - 2'd1;
                    ko_q        <= (health_q <= 2'd1);
                end else if ((stunmode == SM_BLOCK) && (state_q != ST_HITSTUN)
                             && (state_q != ST_BLOCKSTUN)) begin
                    state_q  <= ST_BLOCKSTUN;
                    frames_q <= L_BLOCKSTUN;
                end else if (is_timed(state_q)) begin
                    if (frames_q > 5'd1) begin
                        frames_q <= frames_q - 5'd1;
                    end else begin
                        case (state_q)
                            ST_IA_START: begin
                                state_q  <= ST_IA_ACTIVE;
                                frames_q <= L_IA_ACTIVE;
                            end
                            ST_IA_ACTIVE: begin
                                state_q  <= ST_IA_RECOV;
                                frames_q <= L_IA_RECOV;
                            end
                            ST_DA_START: begin
                                state_q  <= ST_DA_ACTIVE;
                                frames_q <= L_DA_ACTIVE;
                            end
                            ST_DA_ACTIVE: begin
                                state_q  <= ST_DA_RECOV;
                                frames_q <= L_DA_RECOV;
                            end
                            default: begin
                                state_q  <= ST_IDLE;
                                frames_q <= 5'd0;
                            end
                        endcase
                    end
                end else begin
                    if (attack && move_fwd) begin
                        state_q  <= ST_DA_START;
                        frames_q <= L_DA_START;
                    end else if (attack) begin
                        state_q  <= ST_IA_START;
                        frames_q <= L_IA_START;
                    end else if (move_fwd ^ move_back) begin
                        state_q  <= move_fwd ? ST_FORWARD : ST_BACKWARD;
                        frames_q <= 5'd0;
                    end else begin
                        state_q  <= ST_IDLE;
                        frames_q <= 5'd0;
                    end
                end
            end
        end
    end

    assign state       = state_q;
    assign frames_left = frames_q;
    assign health      = health_q;
    assign hit_pulse   = hit_pulse_q;
    assign ko          = ko_q;

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// Self-checking bench for fighter_state_ctrl: vector table plus hand-written
// attack, stun, KO and reset sequences, checked through an expectation queue.
module tb_fighter_state_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] fl;
        logic [1:0] hp;
        logic       pl;
        logic       ko;
    } obs_t;

    typedef struct {
        logic       f;
        logic       b;
        logic       a;
        logic [1:0] sm;
        obs_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_fwd = 1'b0;
    logic       move_back = 1'b0;
    logic       attack = 1'b0;
    logic [1:0] stunmode = 2'b00;
    logic [3:0] state;
    logic [4:0] frames_left;
    logic [1:0] health;
    logic       hit_pulse;
    logic       ko;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    fighter_state_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_fwd(move_fwd), .move_back(move_back), .attack(attack),
        .stunmode(stunmode), .state(state), .frames_left(frames_left),
        .health(health), .hit_pulse(hit_pulse), .ko(ko)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input int st, input int fl, input int hp,
                                input int pl, input int k);
        obs_t o;
        o.st = 4'(st); o.fl = 5'(fl); o.hp = 2'(hp); o.pl = 1'(pl); o.ko = 1'(k);
        return o;
    endfunction

    task automatic compare(input string name);
        obs_t e;
        obs_t g;
        checks++;
        g.st = state; g.fl = frames_left; g.hp = health; g.pl = hit_pulse; g.ko = ko;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued", name);
            return;
        end
        e = exp_q.pop_front();
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got st=%0d fl=%0d hp=%0d pulse=%0d ko=%0d, want st=%0d fl=%0d hp=%0d pulse=%0d ko=%0d",
                     name, g.st, g.fl, g.hp, g.pl, g.ko, e.st, e.fl, e.hp, e.pl, e.ko);
        end
    endtask

    task automatic tick(input string name, input logic f, input logic b, input logic a,
                        input logic [1:0] sm, input obs_t e);
        @(negedge clk);
        move_fwd = f; move_back = b; attack = a; stunmode = sm;
        frame_tick = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        compare(name);
    endtask

    task automatic hold(input string name, input int n, input obs_t e);
        exp_q.push_back(e);
        repeat (n) @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic run_phase(input string name, input logic f, input logic a,
                             input int st, input int len, input int hp);
        for (int k = len; k >= 1; k--)
            tick(name, f, 1'b0, a, 2'b00, ex(st, k, hp, 0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{f:0, b:0, a:0, sm:2'b00, e:ex(0, 0, 3, 0, 0)};
        tbl[1] = '{f:1, b:0, a:0, sm:2'b00, e:ex(1, 0, 3, 0, 0)};
        tbl[2] = '{f:0, b:1, a:0, sm:2'b00, e:ex(2, 0, 3, 0, 0)};
        tbl[3] = '{f:1, b:1, a:0, sm:2'b00, e:ex(0, 0, 3, 0, 0)};
        tbl[4] = '{f:1, b:0, a:0, sm:2'b11, e:ex(1, 0, 3, 0, 0)};
        tbl[5] = '{f:0, b:1, a:0, sm:2'b00, e:ex(2, 0, 3, 0, 0)};
        tbl[6] = '{f:0, b:0, a:0, sm:2'b00, e:ex(0, 0, 3, 0, 0)};

        #12;
        exp_q.push_back(ex(0, 0, 3, 0, 0));
        compare("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            tick($sformatf("table_%0d", i), tbl[i].f, tbl[i].b, tbl[i].a, tbl[i].sm, tbl[i].e);

        // Neutral attack with attack held the whole way: re-arms one tick after IDLE.
        run_phase("ia_start", 1'b0, 1'b1, 3, 5, 3);
        run_phase("ia_active", 1'b0, 1'b1, 4, 2, 3);
        run_phase("ia_recov", 1'b0, 1'b1, 5, 16, 3);
        tick("ia_to_idle", 0, 0, 1, 2'b00, ex(0, 0, 3, 0, 0));
        tick("ia_rearm", 0, 0, 1, 2'b00, ex(3, 5, 3, 0, 0));
        hold("hold_between_ticks", 3, ex(3, 5, 3, 0, 0));
        for (int k = 4; k >= 1; k--)
            tick("ia_start2", 0, 0, 0, 2'b00, ex(3, k, 3, 0, 0));
        run_phase("ia_active2", 1'b0, 1'b0, 4, 2, 3);
        run_phase("ia_recov2", 1'b0, 1'b0, 5, 16, 3);
        tick("ia_end", 0, 0, 0, 2'b00, ex(0, 0, 3, 0, 0));

        run_phase("da_start", 1'b1, 1'b1, 6, 4, 3);
        run_phase("da_active", 1'b1, 1'b0, 7, 3, 3);
        run_phase("da_recov", 1'b1, 1'b0, 8, 15, 3);
        tick("da_end", 0, 0, 0, 2'b00, ex(0, 0, 3, 0, 0));

        tick("trade_setup", 0, 0, 1, 2'b00, ex(3, 5, 3, 0, 0));
        tick("hit_entry", 0, 0, 0, 2'b01, ex(9, 15, 2, 1, 0));
        hold("pulse_one_clock", 1, ex(9, 15, 2, 0, 0));
        tick("hit_held_1", 0, 0, 0, 2'b01, ex(9, 14, 2, 0, 0));
        tick("hit_held_2", 0, 0, 0, 2'b01, ex(9, 13, 2, 0, 0));
        for (int k = 12; k >= 1; k--)
            tick("hitstun", 0, 0, 0, 2'b00, ex(9, k, 2, 0, 0));
        tick("hitstun_end", 0, 0, 0, 2'b00, ex(0, 0, 2, 0, 0));

        tick("blk_setup", 0, 1, 0, 2'b00, ex(2, 0, 2, 0, 0));
        tick("blk_entry", 0, 1, 0, 2'b10, ex(10, 12, 2, 0, 0));
        for (int k = 11; k >= 1; k--)
            tick("blockstun", 0, 1, 0, 2'b00, ex(10, k, 2, 0, 0));
        tick("blk_end", 0, 1, 0, 2'b00, ex(0, 0, 2, 0, 0));
        tick("blk_setup2", 0, 1, 0, 2'b00, ex(2, 0, 2, 0, 0));
        tick("blk_entry2", 0, 1, 0, 2'b10, ex(10, 12, 2, 0, 0));
        tick("blk_dec", 0, 0, 0, 2'b00, ex(10, 11, 2, 0, 0));
        tick("hit_in_block", 0, 0, 0, 2'b01, ex(9, 15, 1, 1, 0));
        tick("block_in_hit", 0, 0, 0, 2'b10, ex(9, 14, 1, 0, 0));
        for (int k = 13; k >= 1; k--)
            tick("hitstun2", 0, 0, 0, 2'b00, ex(9, k, 1, 0, 0));
        tick("hitstun2_end", 0, 0, 0, 2'b00, ex(0, 0, 1, 0, 0));

        tick("ko_hit", 0, 0, 0, 2'b01, ex(9, 15, 0, 1, 1));
        tick("ko_idle", 0, 0, 1, 2'b00, ex(0, 0, 0, 0, 1));
        tick("ko_ignore_hit", 0, 0, 0, 2'b01, ex(0, 0, 0, 0, 1));
        tick("ko_ignore_atk", 1, 0, 1, 2'b10, ex(0, 0, 0, 0, 1));

        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, 3, 0, 0));
        compare("ko_cleared_by_reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_phase("da_start_r", 1'b1, 1'b1, 6, 4, 3);
        tick("da_active_r", 1, 0, 0, 2'b00, ex(7, 3, 3, 0, 0));
        tick("da_active_r", 1, 0, 0, 2'b00, ex(7, 2, 3, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, 3, 0, 0));
        compare("async_reset_mid_da");
        @(negedge clk);
        rst_n = 1'b1;
        tick("after_reset", 0, 0, 0, 2'b00, ex(0, 0, 3, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
